// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants for the iterative shift-add multiplier
package mul_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CLA_SLICE_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/cla_adder_w.sv
// rtl/cla_adder_w.sv - WIDTH-bit adder from chained 4-bit carry-lookahead slices, c_in tied 0
import mul_pkg::*;

module cla_adder_w #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NUM_SLICES = WIDTH / CLA_SLICE_W;

    logic [NUM_SLICES:0] slice_c;

    assign slice_c[0] = 1'b0;
    assign c_out      = slice_c[NUM_SLICES];

    genvar s;
    generate
        for (s = 0; s < NUM_SLICES; s++) begin : g_slice
            logic [3:0] p;
            logic [3:0] g;
            logic [4:0] c;

            assign p    = x[s*CLA_SLICE_W +: CLA_SLICE_W] ^ y[s*CLA_SLICE_W +: CLA_SLICE_W];
            assign g    = x[s*CLA_SLICE_W +: CLA_SLICE_W] & y[s*CLA_SLICE_W +: CLA_SLICE_W];
            assign c[0] = slice_c[s];
            // Lookahead inside the slice; slices ripple into each other.
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

            assign sum[s*CLA_SLICE_W +: CLA_SLICE_W] = p ^ c[3:0];
            assign slice_c[s+1] = c[4];
        end
    endgenerate

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - iterative unsigned WIDTH x WIDTH multiplier with start/done handshake
import mul_pkg::*;

module shift_add_multiplier #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int COUNT_W = $clog2(WIDTH + 1);

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [COUNT_W-1:0] count_q,   count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   add_sum;
    logic               add_c;
    logic [2*WIDTH-1:0] shifted;

    // Adding zero when the multiplier bit is clear also yields carry 0.
    assign add_y = mplier_q[0] ? mcand_q : '0;

    cla_adder_w #(.WIDTH(WIDTH)) u_cla (
        .x     (acc_hi_q),
        .y     (add_y),
        .sum   (add_sum),
        .c_out (add_c)
    );

    assign shifted = {add_c, add_sum, mplier_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        acc_hi_d  = acc_hi_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_hi_d = '0;
                    count_d  = COUNT_W'(WIDTH);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_hi_d = shifted[2*WIDTH-1:WIDTH];
                mplier_d = shifted[WIDTH-1:0];
                count_d  = count_q - COUNT_W'(1);
                if (count_q == COUNT_W'(1)) begin
                    product_d = shifted;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_hi_q  <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier against a*b
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from IDLE and watches a fixed window long enough for one result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit poke,
                          output logic [2*W-1:0] prod, output int lat, output int nbusy,
                          output int ndone, output bit both);
        a = ta;
        b = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        prod  = '0;
        lat   = -1;
        nbusy = 0;
        ndone = 0;
        both  = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            if (busy) nbusy++;
            if (busy && done) both = 1'b1;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat  = k;
                    prod = product;
                end
            end
            if (poke && k >= 1 && k <= 4) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) tick();
        checks++;
        if ({busy, done, product} !== {2'b00, 16'h0000}) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{8'h0F, 8'hFF, 8'h00, 8'h5A};
        logic [W-1:0] tv [4] = '{8'h0F, 8'hFF, 8'hA5, 8'h00};
        logic [2*W-1:0] exp_p [4] = '{16'h00E1, 16'hFE01, 16'h0000, 16'h0000};
        logic [2*W-1:0] prod;
        int lat, nbusy, ndone;
        bit both;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tv[i], 1'b0, prod, lat, nbusy, ndone, both);
            checks++;
            if (prod !== exp_p[i]) begin
                failures++;
                $display("FAIL directed_product[%0d]: got %h required %h", i, prod, exp_p[i]);
            end
            checks++;
            if (lat != W || nbusy != W || ndone != 1 || both) begin
                failures++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d dones=%0d both=%0b required %0d %0d 1 0",
                         i, lat, nbusy, ndone, both, W, W);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [2*W-1:0] prod;
        int lat, nbusy, ndone;
        bit both;
        run_op(8'h33, 8'h44, 1'b1, prod, lat, nbusy, ndone, both);
        checks++;
        if (prod !== 16'h0D8C || ndone != 1 || lat != W) begin
            failures++;
            $display("FAIL ignore_start: got product=%h dones=%0d lat=%0d required 0d8c 1 %0d", prod, ndone, lat, W);
        end
        repeat (5) tick();
        checks++;
        if ({busy, done, product} !== {2'b00, 16'h0D8C}) begin
            failures++;
            $display("FAIL hold_in_idle: got busy=%b done=%b product=%h required 0 0 0d8c", busy, done, product);
        end
    endtask

    task automatic test_async_reset();
        logic [2*W-1:0] prod;
        int lat, nbusy, ndone;
        bit both;
        int seen_done = 0;
        a = 8'h77;
        b = 8'h99;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, product} !== {2'b00, 16'h0000}) begin
            failures++;
            $display("FAIL async_reset: got busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) seen_done++;
            tick();
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL discarded_op: got %0d busy/done cycles required 0", seen_done);
        end
        run_op(8'h12, 8'h34, 1'b0, prod, lat, nbusy, ndone, both);
        checks++;
        if (prod !== 16'h03A8 || lat != W) begin
            failures++;
            $display("FAIL post_reset_op: got product=%h lat=%0d required 03a8 %0d", prod, lat, W);
        end
    endtask

    task automatic test_back_to_back();
        int t_first = -1, t_second = -1;
        logic [2*W-1:0] p_first = '0, p_second = '0;
        a = 8'h02;
        b = 8'h03;
        start = 1'b1;
        tick();
        a = 8'h10;
        b = 8'h10;
        for (int k = 0; k < 40 && t_second < 0; k++) begin
            if (done) begin
                if (t_first < 0) begin
                    t_first = k;
                    p_first = product;
                end else begin
                    t_second = k;
                    p_second = product;
                end
            end else if (t_first >= 0) begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (p_first !== 16'h0006 || p_second !== 16'h0100) begin
            failures++;
            $display("FAIL b2b_products: got %h %h required 0006 0100", p_first, p_second);
        end
        checks++;
        if (t_first < 0 || t_second < 0 || (t_second - t_first) != W + 1) begin
            failures++;
            $display("FAIL b2b_spacing: got first=%0d second=%0d required spacing %0d", t_first, t_second, W + 1);
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] prod;
        int lat, nbusy, ndone;
        bit both;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, bit'($urandom_range(0, 1)), prod, lat, nbusy, ndone, both);
            checks++;
            if (prod !== (2*W)'(ra) * (2*W)'(rb) || lat != W || ndone != 1 || both) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_op[%0d]: a=%h b=%h got product=%h lat=%0d dones=%0d required %h %0d 1",
                             i, ra, rb, prod, lat, ndone, (2*W)'(ra) * (2*W)'(rb), W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
